full_st1_mem_seq: RTL

// Sequencer for the stage-1 fully-connected memory bank (data 32b x 128, bias 32b x 8, tap 192b x 16).

---
 rtl/full_st1_mem_seq.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/full_st1_mem_seq.sv
// full_st1_mem_seq
// Sequencer for the stage-1 fully-connected memory bank (data 32b x 128, bias 32b x 8,
// tap 192b x 16). LOAD streams one input vector into data memory; RUN walks every output
// neuron issuing paired tap/data reads plus one bias read per neuron, and tags the
// returning words (1-cycle read latency) for the MAC datapath.
// Ports:
//   clk, reset (async, active-low)
//   start, cfg_nin/cfg_nout/cfg_ntap : stage control, cfg sampled on an accepted start
//   busy, done, cfg_err              : status (done is a 1-cycle pulse, cfg_err is sticky)
//   in_valid/in_ready/in_data        : input-vector stream
//   data_wr_*                        : data memory write port
//   data_rd_*, tap_rd_*, bias_rd_*   : bank read ports
//   mac_ready, mac_valid/first/last, mac_out_idx : MAC datapath handshake and beat tags
module full_st1_mem_seq #(
    parameter int unsigned DATA_AW = 7,
    parameter int unsigned BIAS_AW = 3,
    parameter int unsigned TAP_AW  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [DATA_AW:0]   cfg_nin,
    input  logic [BIAS_AW:0]   cfg_nout,
    input  logic [TAP_AW:0]    cfg_ntap,
    output logic               busy,
    output logic               done,
    output logic               cfg_err,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_data,
    output logic               data_wr_en,
    output logic [DATA_AW-1:0] data_wr_addr,
    output logic [31:0]        data_wr_data,
    output logic               data_rd_en,
    output logic [DATA_AW-1:0] data_rd_addr,
    output logic               tap_rd_en,
    output logic [TAP_AW-1:0]  tap_rd_addr,
    output logic               bias_rd_en,
    output logic [BIAS_AW-1:0] bias_rd_addr,
    input  logic               mac_ready,
    output logic               mac_valid,
    output logic               mac_first,
    output logic               mac_last,
    output logic [BIAS_AW-1:0] mac_out_idx
);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [DATA_AW:0]   nin_q, nin_d;
    logic [BIAS_AW:0]   nout_q, nout_d;
    logic [TAP_AW:0]    ntap_q, ntap_d;
    logic [DATA_AW-1:0] wcnt_q, wcnt_d;
    logic [TAP_AW-1:0]  k_q, k_d;
    logic [BIAS_AW-1:0] o_q, o_d;
    logic [TAP_AW-1:0]  tap_base_q, tap_base_d;  // o * ntap, kept incrementally
    logic               issued_all_q, issued_all_d;
    logic               cfg_err_q, cfg_err_d;

    logic               wr_en_q, wr_en_d;
    logic [DATA_AW-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]        wr_data_q, wr_data_d;
    logic               step_en_q, step_en_d;     // drives both tap and data read enables
    logic [DATA_AW-1:0] drd_addr_q, drd_addr_d;
    logic [TAP_AW-1:0]  trd_addr_q, trd_addr_d;
    logic               brd_en_q, brd_en_d;
    logic [BIAS_AW-1:0] brd_addr_q, brd_addr_d;
    logic               step_first_q, step_first_d;
    logic               step_last_q, step_last_d;
    logic [BIAS_AW-1:0] step_o_q, step_o_d;

    logic               mac_valid_q, mac_valid_d;
    logic               mac_first_q, mac_first_d;
    logic               mac_last_q, mac_last_d;
    logic [BIAS_AW-1:0] mac_idx_q, mac_idx_d;

    logic cfg_ok, last_wr, last_k, last_o, final_beat;

    always_comb begin
        cfg_ok = (32'(cfg_nin) >= 32'd1) && (32'(cfg_nin) <= (32'd1 << DATA_AW))
              && (32'(cfg_nout) >= 32'd1) && (32'(cfg_nout) <= (32'd1 << BIAS_AW))
              && (32'(cfg_ntap) >= 32'd1) && (32'(cfg_ntap) <= (32'd1 << TAP_AW))
              && (32'(cfg_ntap) <= 32'(cfg_nin))
              && (32'(cfg_nout) * 32'(cfg_ntap) <= (32'd1 << TAP_AW));
        last_wr    = (32'(wcnt_q) + 32'd1 == 32'(nin_q));
        last_k     = (32'(k_q) + 32'd1 == 32'(ntap_q));
        last_o     = (32'(o_q) + 32'd1 == 32'(nout_q));
        // The returning word of the very last step; DONE follows it by one cycle.
        final_beat = mac_valid_q && mac_last_q && (32'(mac_idx_q) + 32'd1 == 32'(nout_q));
    end

    always_comb begin
        state_d      = state_q;
        nin_d        = nin_q;
        nout_d       = nout_q;
        ntap_d       = ntap_q;
        wcnt_d       = wcnt_q;
        k_d          = k_q;
        o_d          = o_q;
        tap_base_d   = tap_base_q;
        issued_all_d = issued_all_q;
        cfg_err_d    = cfg_err_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = '0;
        wr_data_d    = '0;
        step_en_d    = 1'b0;
        drd_addr_d   = '0;
        trd_addr_d   = '0;
        brd_en_d     = 1'b0;
        brd_addr_d   = '0;
        step_first_d = 1'b0;
        step_last_d  = 1'b0;
        step_o_d     = '0;

        // Read data returns one cycle after the read enables.
        mac_valid_d = step_en_q;
        mac_first_d = step_en_q & step_first_q;
        mac_last_d  = step_en_q & step_last_q;
        mac_idx_d   = step_en_q ? step_o_q : '0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (cfg_ok) begin
                        nin_d        = cfg_nin;
                        nout_d       = cfg_nout;
                        ntap_d       = cfg_ntap;
                        wcnt_d       = '0;
                        k_d          = '0;
                        o_d          = '0;
                        tap_base_d   = '0;
                        issued_all_d = 1'b0;
                        cfg_err_d    = 1'b0;
                        state_d      = StLoad;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                if (in_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = wcnt_q;
                    wr_data_d = in_data;
                    if (last_wr) begin
                        state_d = StRun;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            StRun: begin
                if (!issued_all_q && mac_ready) begin
                    step_en_d    = 1'b1;
                    trd_addr_d   = tap_base_q + k_q;
                    drd_addr_d   = DATA_AW'(k_q);
                    brd_en_d     = (k_q == '0);
                    brd_addr_d   = (k_q == '0) ? o_q : '0;
                    step_first_d = (k_q == '0);
                    step_last_d  = last_k;
                    step_o_d     = o_q;
                    if (last_k) begin
                        k_d = '0;
                        if (last_o) begin
                            issued_all_d = 1'b1;
                        end else begin
                            o_d        = o_q + 1'b1;
                            tap_base_d = tap_base_q + TAP_AW'(ntap_q);
                        end
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
                if (final_beat) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            nin_q        <= '0;
            nout_q       <= '0;
            ntap_q       <= '0;
            wcnt_q       <= '0;
            k_q          <= '0;
            o_q          <= '0;
            tap_base_q   <= '0;
            issued_all_q <= 1'b0;
            cfg_err_q    <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            step_en_q    <= 1'b0;
            drd_addr_q   <= '0;
            trd_addr_q   <= '0;
            brd_en_q     <= 1'b0;
            brd_addr_q   <= '0;
            step_first_q <= 1'b0;
            step_last_q  <= 1'b0;
            step_o_q     <= '0;
            mac_valid_q  <= 1'b0;
            mac_first_q  <= 1'b0;
            mac_last_q   <= 1'b0;
            mac_idx_q    <= '0;
        end else begin
            state_q      <= state_d;
            nin_q        <= nin_d;
            nout_q       <= nout_d;
            ntap_q       <= ntap_d;
            wcnt_q       <= wcnt_d;
            k_q          <= k_d;
            o_q          <= o_d;
            tap_base_q   <= tap_base_d;
            issued_all_q <= issued_all_d;
            cfg_err_q    <= cfg_err_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            step_en_q    <= step_en_d;
            drd_addr_q   <= drd_addr_d;
            trd_addr_q   <= trd_addr_d;
            brd_en_q     <= brd_en_d;
            brd_addr_q   <= brd_addr_d;
            step_first_q <= step_first_d;
            step_last_q  <= step_last_d;
            step_o_q     <= step_o_d;
            mac_valid_q  <= mac_valid_d;
            mac_first_q  <= mac_first_d;
            mac_last_q   <= mac_last_d;
            mac_idx_q    <= mac_idx_d;
        end
    end

    assign busy         = (state_q == StLoad) || (state_q == StRun);
    assign done         = (state_q == StDone);
    assign in_ready     = (state_q == StLoad);
    assign cfg_err      = cfg_err_q;
    assign data_wr_en   = wr_en_q;
    assign data_wr_addr = wr_addr_q;
    assign data_wr_data = wr_data_q;
    assign data_rd_en   = step_en_q;
    assign data_rd_addr = drd_addr_q;
    assign tap_rd_en    = step_en_q;
    assign tap_rd_addr  = trd_addr_q;
    assign bias_rd_en   = brd_en_q;
    assign bias_rd_addr = brd_addr_q;
    assign mac_valid    = mac_valid_q;
    assign mac_first    = mac_first_q;
    assign mac_last     = mac_last_q;
    assign mac_out_idx  = mac_idx_q;

endmodule
